spike_aer_encoder: RTL and testbench
====================================

# spike_aer_encoder

Output-side companion to the neuron network: it captures the per-timestep spike vector the network produces and serialises it into address-event representation (AER) words, one word per firing neuron, tagged with a timestep stamp. Events are buffered in a small FIFO and drained over a valid/ready stream toward the chip pins or a host-side collector. Dropped timesteps are counted so the bench and the host can detect lost activity.

## Interface
- NEURONS, 4: width of the spike vector (neurons in the output layer)
- ADDR_W, 2: neuron address width, must equal clog2(NEURONS)
- TS_W, 4: timestep stamp width
- FIFO_DEPTH, 4: event FIFO entries, power of two
- clk  in  1  single clock for the whole block
- reset  in  1  asynchronous, active-high reset
- spike_valid  in  1  one-cycle strobe: network finished a timestep, spikes valid
- spikes  in  NEURONS  spike vector, bit i = neuron i fired
- aer_valid  out  1  event word available
- aer_ready  in  1  consumer accepts the word this cycle
- aer_data  out  TS_W+ADDR_W  event word {ts, addr}
- busy  out  1  pending vector not yet fully scanned
- overflow  out  1  sticky: at least one vector dropped since reset
- drop_count  out  8  dropped vectors, saturates at 255

## Operation
- Timestamp counter ts_cnt (TS_W bits) increments on every spike_valid, including zero and dropped vectors; wraps from all-ones to 0.
- Capture: on spike_valid, if accepted, pending <= spikes and pend_ts <= ts_cnt (value before increment).
- Acceptance: accepted if pending == 0, or pending has exactly one bit set and that bit is emitted the same cycle. Otherwise the vector is dropped: overflow <= 1, drop_count += 1 (saturating); pending unchanged.
- spikes == 0 with spike_valid: ts_cnt advances, nothing emitted, not a drop.
- States: IDLE (pending == 0) and SCAN (pending != 0). IDLE -> SCAN on accepted non-zero vector; SCAN -> IDLE when the last bit is emitted and no new vector is accepted; SCAN -> SCAN on back-to-back accept.
- Scan: in SCAN, if FIFO not full, push {pend_ts, addr} where addr = lowest set index in pending, and clear that bit. One push per cycle, ascending address order. FIFO full -> scan stalls, pending held.
- FIFO: show-ahead; aer_data is the head entry, aer_valid = !empty. Pop when aer_valid && aer_ready. Push and pop in the same cycle when full is allowed only if pop frees the slot: full status uses registered count, so a push is refused when full even if popping (no bypass).
- busy = (state == SCAN).
- Reset mid-operation: pending, FIFO contents, ts_cnt, overflow, drop_count all cleared immediately; in-flight events are lost.

## Timing
- Reset values: aer_valid 0, aer_data 0, busy 0, overflow 0, drop_count 0; ts_cnt 0.
- Latency: spike_valid at cycle N -> pending valid at N+1 -> first push at N+1 edge -> aer_valid high in cycle N+2 (with FIFO empty and not full).
- Throughput: 1 event per cycle sustained when aer_ready held high.
- A vector with k set bits occupies SCAN for k cycles minimum; next spike_valid is accepted no earlier than the cycle its last bit is emitted.
- aer_data/aer_valid must stay stable while aer_valid && !aer_ready.
- overflow and drop_count update the cycle after the dropped spike_valid.

## Structure
- Package spike_aer_pkg: localparams for default widths, the event word layout (ts field MSBs, addr field LSBs), state encoding IDLE/SCAN, and a lowest-set-bit priority function.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): registered pointers and count, full/empty flags, show-ahead read. Encoder holds capture, ts counter, scan FSM, and drop statistics.

## Test plan
- Single vector spikes=4'b1011 at ts 0, aer_ready=1 -> words {0,0},{0,1},{0,3} on consecutive cycles, first aer_valid 2 cycles after strobe; busy low after.
- Back-to-back: 4'b0001 then 4'b0010 on the next cycle -> second accepted (single-bit handoff), words {0,0},{1,1}, overflow stays 0.
- Drop: 4'b1111 then 4'b0100 one cycle later -> second dropped, overflow=1, drop_count=1, only ts-0 words for addresses 0..3 emitted.
- Backpressure: aer_ready=0, vector 4'b1111 -> FIFO fills with 4 words, busy stays 0 after 4 pushes only when pending empties; release aer_ready -> words drained in order, data stable while stalled.
- Wrap and zero vectors: 16 strobes of 0 then 4'b1000 -> word {0,3} (ts wrapped), no drops counted; 300 forced drops -> drop_count saturates at 255.
- Reset asserted mid-scan with FIFO non-empty -> aer_valid, busy, overflow, drop_count go 0 asynchronously; next vector after release stamped ts 0.

Source files
------------

// File: rtl/spike_aer_pkg.sv
// Shared widths, event-word layout, scan FSM encoding and the priority helper
// for the spike-to-AER encoder.
package spike_aer_pkg;
  localparam int NEURONS_DEF    = 4;
  localparam int ADDR_W_DEF     = 2;
  localparam int TS_W_DEF       = 4;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int LSB_MAX_W      = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SCAN = 1'b1;

  // Event word: timestep stamp in the MSBs, neuron address in the LSBs.
  typedef struct packed {
    logic [TS_W_DEF-1:0]   ts;
    logic [ADDR_W_DEF-1:0] addr;
  } aer_word_t;

  function automatic int unsigned lsb_index(input logic [LSB_MAX_W-1:0] v);
    lsb_index = 0;
    for (int i = LSB_MAX_W - 1; i >= 0; i--)
      if (v[i]) lsb_index = i;
  endfunction
endpackage

// File: rtl/spike_aer_if.sv
// Spike-vector input and AER event stream; master is the encoder side.
interface spike_aer_if #(
    parameter int NEURONS = 4,
    parameter int TS_W    = 4,
    parameter int ADDR_W  = 2
);
    logic                   spike_valid;
    logic [NEURONS-1:0]     spikes;
    logic                   aer_valid;
    logic                   aer_ready;
    logic [TS_W+ADDR_W-1:0] aer_data;

    modport master (
        input  spike_valid, spikes, aer_ready,
        output aer_valid, aer_data
    );
    modport slave (
        output spike_valid, spikes, aer_ready,
        input  aer_valid, aer_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from the registered count,
// so a push into a full FIFO is refused even when a pop happens that cycle.
module sync_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push, do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Gate the head so stale storage never leaks out after reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/spike_aer_encoder.sv
// Captures per-timestep spike vectors, serialises set bits into {ts, addr}
// event words lowest address first, and counts vectors it had to drop.
module spike_aer_encoder
    import spike_aer_pkg::*;
#(
    parameter int NEURONS    = NEURONS_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int TS_W       = TS_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    spike_aer_if.master bus,
    output logic       busy,
    output logic       overflow,
    output logic [7:0] drop_count
);
    localparam int EVT_W = TS_W + ADDR_W;

    logic [0:0]         state, state_nxt;
    logic [NEURONS-1:0] pending, remaining, pending_nxt;
    logic [TS_W-1:0]    ts_cnt, pend_ts;
    logic [ADDR_W-1:0]  scan_addr;
    logic [EVT_W-1:0]   push_data;
    logic               fifo_full, fifo_empty;
    logic               emit, accept, drop;

    assign scan_addr = ADDR_W'(lsb_index(LSB_MAX_W'(pending)));
    assign emit      = (state == ST_SCAN) && !fifo_full;
    assign remaining = emit ? (pending & (pending - NEURONS'(1))) : pending;
    // A new vector fits only if the scan finishes this very cycle.
    assign accept    = bus.spike_valid && (remaining == '0);
    assign drop      = bus.spike_valid && (bus.spikes != '0) && !accept;
    assign pending_nxt = accept ? bus.spikes : remaining;
    assign state_nxt   = (pending_nxt != '0) ? ST_SCAN : ST_IDLE;
    assign push_data   = {pend_ts, scan_addr};
    assign busy        = (state == ST_SCAN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            pending    <= '0;
            pend_ts    <= '0;
            ts_cnt     <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            if (bus.spike_valid) ts_cnt <= ts_cnt + TS_W'(1);
            if (accept)          pend_ts <= ts_cnt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    sync_fifo #(.WIDTH(EVT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (emit),
        .push_data (push_data),
        .pop       (!fifo_empty && bus.aer_ready),
        .rd_data   (bus.aer_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.aer_valid = !fifo_empty;
endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder: stimulus pushes expected words into a
// queue, a negedge monitor pops and compares each accepted word.
module tb_spike_aer_encoder;
  import spike_aer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy, overflow;
  logic [7:0] drop_count;

  always #5 clk = ~clk;

  spike_aer_if #(.NEURONS(4), .TS_W(4), .ADDR_W(2)) bus ();

  spike_aer_encoder #(.NEURONS(4), .ADDR_W(2), .TS_W(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.master),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  int        total = 0;
  int        bad   = 0;
  aer_word_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic aer_word_t word(input int ts, input int addr);
    aer_word_t w;
    w.ts   = 4'(ts);
    w.addr = 2'(addr);
    return w;
  endfunction

  // Monitor: score accepted words and hold-stability during backpressure.
  logic      prev_stall = 1'b0;
  aer_word_t prev_data;
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        check("stall_valid", 32'(bus.aer_valid), 32'd1);
        check("stall_data", 32'(bus.aer_data), 32'(prev_data));
      end
      if (bus.aer_valid && bus.aer_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", bus.aer_data);
        end else check("aer_word", 32'(bus.aer_data), 32'(exp_q.pop_front()));
      end
      prev_stall = bus.aer_valid && !bus.aer_ready;
      prev_data  = bus.aer_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] v);
    bus.spike_valid = 1'b1;
    bus.spikes      = v;
    tick();
    bus.spike_valid = 1'b0;
    bus.spikes      = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < maxc) begin
      tick();
      n++;
    end
    check("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.spike_valid = 1'b0;
    bus.spikes      = '0;
    bus.aer_ready   = 1'b0;
    tick();
    tick();
    check("rst_aer_valid", 32'(bus.aer_valid), 32'd0);
    check("rst_aer_data", 32'(bus.aer_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // Single vector: latency 2, one word per cycle.
    bus.aer_ready = 1'b1;
    exp_q.push_back(word(0, 0));
    exp_q.push_back(word(0, 1));
    exp_q.push_back(word(0, 3));
    strobe(4'b1011);
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_early_valid", 32'(bus.aer_valid), 32'd0);
    tick();
    check("lat_valid_n2", 32'(bus.aer_valid), 32'd1);
    tick();
    check("thru_valid_1", 32'(bus.aer_valid), 32'd1);
    tick();
    check("thru_valid_2", 32'(bus.aer_valid), 32'd1);
    check("busy_cleared", 32'(busy), 32'd0);
    tick();
    check("valid_cleared", 32'(bus.aer_valid), 32'd0);
    wait_drain(20);

    // Back-to-back single-bit handoff.
    do_reset();
    bus.aer_ready = 1'b1;
    exp_q.push_back(word(0, 0));
    exp_q.push_back(word(1, 1));
    strobe(4'b0001);
    strobe(4'b0010);
    wait_drain(20);
    check("b2b_overflow", 32'(overflow), 32'd0);
    check("b2b_drop_count", 32'(drop_count), 32'd0);

    // Drop while a multi-bit vector is still scanning.
    do_reset();
    bus.aer_ready = 1'b1;
    for (int a = 0; a < 4; a++) exp_q.push_back(word(0, a));
    strobe(4'b1111);
    strobe(4'b0100);
    check("drop_overflow", 32'(overflow), 32'd1);
    check("drop_count_1", 32'(drop_count), 32'd1);
    wait_drain(20);
    check("drop_count_hold", 32'(drop_count), 32'd1);

    // Backpressure: FIFO fills, scan stalls with a bit still pending.
    do_reset();
    bus.aer_ready = 1'b0;
    exp_q.push_back(word(0, 0));
    exp_q.push_back(word(0, 1));
    exp_q.push_back(word(1, 0));
    exp_q.push_back(word(1, 1));
    exp_q.push_back(word(1, 2));
    strobe(4'b0011);
    tick();
    tick();
    strobe(4'b0111);
    repeat (5) tick();
    check("bp_busy_stalled", 32'(busy), 32'd1);
    check("bp_valid", 32'(bus.aer_valid), 32'd1);
    check("bp_head", 32'(bus.aer_data), 32'(word(0, 0)));
    check("bp_no_drop", 32'(drop_count), 32'd0);
    bus.aer_ready = 1'b1;
    wait_drain(30);

    // Timestamp wrap through zero vectors.
    do_reset();
    bus.aer_ready = 1'b1;
    repeat (16) strobe(4'b0000);
    exp_q.push_back(word(0, 3));
    strobe(4'b1000);
    wait_drain(20);
    check("wrap_drop_count", 32'(drop_count), 32'd0);
    check("wrap_overflow", 32'(overflow), 32'd0);

    // Saturating drop counter: FIFO full, pending stuck, 300 drops.
    do_reset();
    bus.aer_ready = 1'b0;
    strobe(4'b1111);
    repeat (5) tick();
    strobe(4'b1111);
    bus.spike_valid = 1'b1;
    bus.spikes      = 4'b0001;
    repeat (254) tick();
    bus.spike_valid = 1'b0;
    check("sat_count_254", 32'(drop_count), 32'd254);
    check("sat_overflow", 32'(overflow), 32'd1);
    bus.spike_valid = 1'b1;
    repeat (46) tick();
    bus.spike_valid = 1'b0;
    bus.spikes      = '0;
    check("sat_count_255", 32'(drop_count), 32'd255);

    // Asynchronous reset mid-scan with FIFO holding words.
    do_reset();
    bus.aer_ready = 1'b0;
    strobe(4'b1111);
    strobe(4'b0100);
    tick();
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("async_aer_valid", 32'(bus.aer_valid), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_overflow", 32'(overflow), 32'd0);
    check("async_drop_count", 32'(drop_count), 32'd0);
    tick();
    reset = 1'b0;
    bus.aer_ready = 1'b1;
    exp_q.push_back(word(0, 2));
    strobe(4'b0100);
    wait_drain(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
